// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: imem port, redirect port and the
// decode-facing valid/ready head of the queue.
interface instr_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [31:0]   instr_out;
    logic [31:0]   pcplus4_out;
    logic          valid_out;
    logic          ready_in;
    logic [CW-1:0] count;
    logic          halted;

    modport slave (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_out,
        output pcplus4_out,
        output valid_out,
        input  ready_in,
        output count,
        output halted
    );

    modport master (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_out,
        input  pcplus4_out,
        input  valid_out,
        output ready_in,
        input  count,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Sequential fetch front end: fetch PC, {instr, pc+4} FIFO,
// redirect flush and halt-word freeze.
module instr_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic                 CLK,
    input logic                 RSTn,
    instr_fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetchPc;
    logic [31:0]   fetchPcNext;
    logic [31:0]   pcPlus4;
    logic [31:0]   instrMem [DEPTH];
    logic [31:0]   pcMem    [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] rdPtrNext;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] wrPtrNext;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic          haltedQ;
    logic          haltedNext;

    logic redir;
    logic headValid;
    logic full;
    logic isHalt;
    logic pop;
    logic push;

    assign redir     = bus.redirect_valid;
    assign headValid = (cnt != '0);
    assign full      = (cnt == FULL);
    assign isHalt    = (bus.imem_data == HALT_WORD);
    assign pcPlus4   = fetchPc + 32'd4;

    // Redirect wins: the head shown this cycle is dropped, not popped.
    assign pop  = headValid & bus.ready_in & ~redir;
    assign push = ~haltedQ & ~redir & (~full | pop);

    always_comb begin
        fetchPcNext = fetchPc;
        if (redir)
            fetchPcNext = bus.redirect_pc;
        else if (push && !isHalt)
            fetchPcNext = pcPlus4;
    end

    always_comb begin
        haltedNext = haltedQ;
        if (redir)
            haltedNext = 1'b0;
        else if (push && isHalt)
            haltedNext = 1'b1;
    end

    always_comb begin
        wrPtrNext = wrPtr;
        rdPtrNext = rdPtr;
        if (redir) begin
            wrPtrNext = '0;
            rdPtrNext = '0;
        end else begin
            if (push)
                wrPtrNext = wrPtr + 1'b1;
            if (pop)
                rdPtrNext = rdPtr + 1'b1;
        end
    end

    always_comb begin
        cntNext = cnt;
        unique case (1'b1)
            redir:          cntNext = '0;
            push && !pop:   cntNext = cnt + 1'b1;
            pop  && !push:  cntNext = cnt - 1'b1;
            default:        cntNext = cnt;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fetchPc <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            cnt     <= '0;
            haltedQ <= 1'b0;
        end else begin
            fetchPc <= fetchPcNext;
            rdPtr   <= rdPtrNext;
            wrPtr   <= wrPtrNext;
            cnt     <= cntNext;
            haltedQ <= haltedNext;
        end
    end

    // Storage needs no reset: outputs are gated by the occupancy count.
    always_ff @(posedge CLK) begin
        if (push) begin
            instrMem[wrPtr] <= bus.imem_data;
            pcMem[wrPtr]    <= pcPlus4;
        end
    end

    assign bus.imem_addr   = fetchPc;
    assign bus.valid_out   = headValid;
    assign bus.instr_out   = headValid ? instrMem[rdPtr] : 32'd0;
    assign bus.pcplus4_out = headValid ? pcMem[rdPtr] : 32'd0;
    assign bus.count       = cnt;
    assign bus.halted      = haltedQ;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a small
// combinational instruction memory model.
module tb_instr_fetch_queue;
    logic CLK;
    logic RSTn;
    int   checks;
    int   errors;

    logic [31:0] mem [64];

    instr_fetch_queue_if #(.DEPTH(4)) bus ();

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr[7:2]];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyReset();
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if (bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr got %h want 0", bus.imem_addr);
        end
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", bus.count);
        end
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", bus.valid_out);
        end
        if (bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_halted got %b want 0", bus.halted);
        end
        if (bus.instr_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_instr got %h want 0", bus.instr_out);
        end
        if (bus.pcplus4_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc4 got %h want 0", bus.pcplus4_out);
        end
    endtask

    task automatic test_stream();
        logic [31:0] expI [4];
        logic [31:0] expP [4];
        expI = '{32'h20080001, 32'h20090002, 32'h01095020, 32'hFFFFFFFF};
        expP = '{32'd4, 32'd8, 32'd12, 32'd16};
        bus.ready_in = 1'b1;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 3;
            if (bus.valid_out !== 1'b1) begin
                errors++;
                $display("FAIL stream_valid[%0d] got %b want 1", i, bus.valid_out);
            end
            if (bus.instr_out !== expI[i]) begin
                errors++;
                $display("FAIL stream_instr[%0d] got %h want %h", i, bus.instr_out, expI[i]);
            end
            if (bus.pcplus4_out !== expP[i]) begin
                errors++;
                $display("FAIL stream_pc4[%0d] got %h want %h", i, bus.pcplus4_out, expP[i]);
            end
        end
        checks += 2;
        if (bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL stream_halted got %b want 1", bus.halted);
        end
        if (bus.imem_addr !== 32'h0C) begin
            errors++;
            $display("FAIL stream_haltaddr got %h want 0c", bus.imem_addr);
        end
        tick();
        checks += 3;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid got %b want 0", bus.valid_out);
        end
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL drain_count got %0d want 0", bus.count);
        end
        if (bus.imem_addr !== 32'h0C) begin
            errors++;
            $display("FAIL drain_addr got %h want 0c", bus.imem_addr);
        end
    endtask

    task automatic test_halt_redirect();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h08;
        tick();
        bus.redirect_valid = 1'b0;
        checks += 3;
        if (bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL hr_halted got %b want 0", bus.halted);
        end
        if (bus.imem_addr !== 32'h08) begin
            errors++;
            $display("FAIL hr_addr got %h want 08", bus.imem_addr);
        end
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL hr_valid got %b want 0", bus.valid_out);
        end
        tick();
        checks += 2;
        if (bus.pcplus4_out !== 32'h0C) begin
            errors++;
            $display("FAIL hr_pc4a got %h want 0c", bus.pcplus4_out);
        end
        if (bus.instr_out !== 32'h01095020) begin
            errors++;
            $display("FAIL hr_instra got %h want 01095020", bus.instr_out);
        end
        tick();
        checks += 2;
        if (bus.pcplus4_out !== 32'h10) begin
            errors++;
            $display("FAIL hr_pc4b got %h want 10", bus.pcplus4_out);
        end
        if (bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL hr_rehalt got %b want 1", bus.halted);
        end
        tick();
    endtask

    task automatic test_stall();
        mem[3]  = 32'h00000013;
        mem[4]  = 32'h00A00093;
        mem[63] = 32'h00100113;
        bus.ready_in = 1'b0;
        applyReset();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.count !== 3'(i)) begin
                errors++;
                $display("FAIL stall_count[%0d] got %0d want %0d", i, bus.count, i);
            end
        end
        tick();
        checks += 2;
        if (bus.count !== 3'd4) begin
            errors++;
            $display("FAIL stall_hold got %0d want 4", bus.count);
        end
        if (bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL stall_addr got %h want 10", bus.imem_addr);
        end
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        checks += 3;
        if (bus.count !== 3'd4) begin
            errors++;
            $display("FAIL popush_count got %0d want 4", bus.count);
        end
        if (bus.imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL popush_addr got %h want 14", bus.imem_addr);
        end
        if (bus.pcplus4_out !== 32'h08) begin
            errors++;
            $display("FAIL popush_head got %h want 08", bus.pcplus4_out);
        end
        // flush while full and stalled, target at the top of memory
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        checks += 2;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL fullredir_count got %0d want 0", bus.count);
        end
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL fullredir_addr got %h want fffffffc", bus.imem_addr);
        end
        bus.ready_in = 1'b1;
        tick();
        checks += 3;
        if (bus.instr_out !== 32'h00100113) begin
            errors++;
            $display("FAIL wrap_instr got %h want 00100113", bus.instr_out);
        end
        if (bus.pcplus4_out !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4 got %h want 0", bus.pcplus4_out);
        end
        if (bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr got %h want 0", bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.instr_out !== 32'h20080001) begin
            errors++;
            $display("FAIL wrap_next got %h want 20080001", bus.instr_out);
        end
    endtask

    task automatic test_redirect();
        mem[16] = 32'h11111111;
        mem[17] = 32'h22222222;
        bus.ready_in = 1'b0;
        applyReset();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL redir_pre got %0d want 3", bus.count);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.ready_in       = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        checks += 4;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL redir_count got %0d want 0", bus.count);
        end
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL redir_valid got %b want 0", bus.valid_out);
        end
        if (bus.instr_out !== 32'h0) begin
            errors++;
            $display("FAIL redir_instr got %h want 0", bus.instr_out);
        end
        if (bus.imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL redir_addr got %h want 40", bus.imem_addr);
        end
        tick();
        checks += 3;
        if (bus.pcplus4_out !== 32'h44) begin
            errors++;
            $display("FAIL redir_pc4a got %h want 44", bus.pcplus4_out);
        end
        if (bus.instr_out !== 32'h11111111) begin
            errors++;
            $display("FAIL redir_instra got %h want 11111111", bus.instr_out);
        end
        if (bus.count !== 3'd1) begin
            errors++;
            $display("FAIL redir_cnta got %0d want 1", bus.count);
        end
        tick();
        checks += 2;
        if (bus.pcplus4_out !== 32'h48) begin
            errors++;
            $display("FAIL redir_pc4b got %h want 48", bus.pcplus4_out);
        end
        if (bus.instr_out !== 32'h22222222) begin
            errors++;
            $display("FAIL redir_instrb got %h want 22222222", bus.instr_out);
        end
    endtask

    task automatic test_async_reset();
        bus.ready_in = 1'b0;
        applyReset();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL ar_pre got %0d want 3", bus.count);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #2;
        RSTn = 1'b0;
        #1;
        checks += 4;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL ar_count got %0d want 0", bus.count);
        end
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL ar_valid got %b want 0", bus.valid_out);
        end
        if (bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL ar_addr got %h want 0", bus.imem_addr);
        end
        if (bus.instr_out !== 32'h0) begin
            errors++;
            $display("FAIL ar_instr got %h want 0", bus.instr_out);
        end
        bus.redirect_valid = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        bus.ready_in = 1'b1;
        tick();
        checks += 2;
        if (bus.pcplus4_out !== 32'h04) begin
            errors++;
            $display("FAIL ar_resume got %h want 04", bus.pcplus4_out);
        end
        if (bus.imem_addr !== 32'h04) begin
            errors++;
            $display("FAIL ar_raddr got %h want 04", bus.imem_addr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h20080001;
        mem[1] = 32'h20090002;
        mem[2] = 32'h01095020;
        mem[3] = 32'hFFFFFFFF;
        RSTn               = 1'b0;
        bus.ready_in       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        test_reset();
        test_stream();
        test_halt_redirect();
        test_stall();
        test_redirect();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Sequential instruction-fetch front end that sits between the instruction memory and the IF/ID pipeline register. It drives the fetch address and captures each returned instruction word, together with its PC+4, into a small FIFO. The FIFO head is presented to decode through a valid/ready handshake, so a decode stall does not stop fetching until the queue fills. A branch, jump or jr redirect flushes the queue and restarts fetch at the target. Fetch halts when the halt word is captured.

## Interface
- DEPTH, 4: queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that stops fetch.
- CLK  in  1  single clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte fetch address; memory is indexed with imem_addr>>2.
- imem_data  in  32  instruction word; combinational read of imem_addr, valid in the same cycle.
- redirect_valid  in  1  one-cycle redirect request from ID (branch taken, j, jal, jr).
- redirect_pc  in  32  target byte address, sampled when redirect_valid=1.
- instr_out  out  32  instruction at the queue head.
- pcplus4_out  out  32  PC+4 of the head instruction.
- valid_out  out  1  head entry is valid.
- ready_in  in  1  decode accepts the head this cycle; low means decode is stalled.
- count  out  log2(DEPTH)+1  current occupancy.
- halted  out  1  the halt word has been enqueued; fetch is frozen.

## Operation
- State: fetch PC register, circular storage of DEPTH entries of {instr, pc+4}, read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, an occupancy counter, and the halted flag.
- imem_addr equals the fetch PC at all times.
- pop = valid_out & ready_in & ~redirect_valid.
- push = ~halted & ~redirect_valid & (count<DEPTH | pop).
  - When full, a push is allowed in the same cycle as a pop.
- On push:
  - Write {imem_data, fetch PC+4} at the write pointer and advance the write pointer.
  - If imem_data==HALT_WORD, set halted=1 and hold the fetch PC.
  - Otherwise set fetch PC to fetch PC+4.
- On pop: advance the read pointer.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Redirect has priority over everything else:
  - Pointers and count go to 0 and halted goes to 0.
  - Fetch PC is loaded with redirect_pc.
  - There is no push and no pop in that cycle; the head shown to decode that cycle is discarded.
- Output gating:
  - valid_out = (count!=0).
  - instr_out and pcplus4_out are 0 when valid_out=0, else the head entry.
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- redirect_pc is used as given; bits [1:0] are not checked.
- The halt entry is itself delivered to decode like any other entry.

## Timing
- Reset (asynchronous assert, synchronous release on the first rising CLK edge):
  - imem_addr=RESET_PC.
  - count=0, valid_out=0, halted=0.
  - instr_out=0, pcplus4_out=0.
- Reset applied mid-operation discards all entries and any pending redirect immediately.
- First rising edge after RSTn goes high: mem[RESET_PC>>2] is enqueued, and valid_out=1 from then on.
- Fetch-to-decode latency is one edge: an instruction on imem_data at edge k is at the head after edge k when the queue was empty.
- Throughput is one instruction per cycle while ready_in=1.
- A decode stall fills the queue in at most DEPTH cycles. After that, imem_addr holds and push=0 until a pop.
- Redirect sampled at edge k:
  - imem_addr=redirect_pc and valid_out=0 after edge k.
  - The target instruction is valid at the head after edge k+1.
  - Two-cycle bubble in total.
- Redirect while halted: fetch resumes normally at redirect_pc.
- Redirect while full and stalled: the flush still occurs. ready_in is ignored that cycle.

## Test plan
- Reset release with mem[0..3]=0x20080001, 0x20090002, 0x01095020, 0xFFFFFFFF, ready_in=1 -> heads 0x20080001/pcplus4 4, 0x20090002/8, 0x01095020/12, 0xFFFFFFFF/16 on consecutive cycles. halted=1 after the 4th edge, imem_addr stays 0x0C, valid_out=0 after the halt entry pops.
- ready_in=0 from reset, DEPTH=4 -> count goes 1,2,3,4 then holds, imem_addr=0x10 frozen. Raising ready_in for one cycle gives one pop and one push in the same cycle: count stays 4 and imem_addr becomes 0x14.
- redirect_valid=1, redirect_pc=0x40, with 3 entries queued -> count=0 and valid_out=0 next cycle; head pcplus4_out=0x44 one cycle later, with no stale entry ever presented.
- redirect_valid=1 with ready_in=1 and head valid in the same cycle -> no pop is counted and the queue is empty after the edge. Following entries come only from the target.
- Halted queue followed by redirect to 0x08 -> halted=0 and fetch restarts: heads at pcplus4 0x0C, 0x10, ...
- RSTn pulsed low mid-stream with count=3 -> count=0, valid_out=0 and imem_addr=RESET_PC immediately, without waiting for a CLK edge.
